// File: rtl/audio_mixer_pkg.sv
// Shared constants and width helpers for the audio mixer and its neighbours.
package audio_mixer_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned unity_gain(input int unsigned gain_w);
    return 32'd1 << (gain_w - 1);
  endfunction

  // Wide enough that summing every channel at full scale and full gain cannot wrap
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned gain_w,
                                            input int unsigned num_ch);
    return in_w + gain_w + 1 + clog2(num_ch);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_SAT
  } mix_state_e;

endpackage

// File: rtl/sample_strobe_sync.sv
// 2-FF synchroniser plus rising-edge detector producing a one-cycle clk32 strobe.
module sample_strobe_sync (
  input  logic clk32,
  input  logic rst,
  input  logic async_i,
  output logic strobe_o
);

  logic       s1, s2, s3;
  logic       armed;
  logic [1:0] fill;

  // armed only after a genuine low has passed the synchroniser, so a level
  // already high at reset release is not mistaken for a rising edge
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      fill     <= 2'd0;
      armed    <= 1'b0;
      strobe_o <= 1'b0;
    end else begin
      s1       <= async_i;
      s2       <= s1;
      s3       <= s2;
      if (fill != 2'd2) fill <= fill + 2'd1;
      armed    <= armed | ((fill == 2'd2) & ~s2);
      strobe_o <= armed & s2 & ~s3;
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// N-channel stereo mixer: snapshot on sample strobe, shared-multiplier MAC,
// arithmetic-shift rescale and saturation to one registered stereo sample.
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned GAIN_W = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk32,
  input  logic                     rst,
  input  logic                     sample_clk_i,
  input  logic [NUM_CH*IN_W-1:0]   ch_data_i,
  input  logic [NUM_CH*GAIN_W-1:0] gain_i,
  input  logic [NUM_CH-1:0]        route_l_i,
  input  logic [NUM_CH-1:0]        route_r_i,
  input  logic                     mute_i,
  input  logic                     clr_flags_i,
  output logic [OUT_W-1:0]         left_o,
  output logic [OUT_W-1:0]         right_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     clip_l_o,
  output logic                     clip_r_o,
  output logic                     overrun_o
);

  localparam int unsigned ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int unsigned PROD_W = IN_W + GAIN_W + 1;
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int unsigned UNITY  = unity_gain(GAIN_W);
  localparam int unsigned SHIFT  = clog2(UNITY);

  // Returns {clip, value}: floor-rescale by unity, then clamp to signed OUT_W
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    logic [ACC_W-OUT_W:0]    hi;
    r  = acc >>> SHIFT;
    hi = r[ACC_W-1:OUT_W-1];
    if ((&hi) || (~|hi)) return {1'b0, r[OUT_W-1:0]};
    else if (r[ACC_W-1]) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else                 return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  mix_state_e state, state_nxt;
  logic strobe;

  logic [NUM_CH*IN_W-1:0]   snap_data;
  logic [NUM_CH*GAIN_W-1:0] snap_gain;
  logic [NUM_CH-1:0]        snap_rl, snap_rr;
  logic                     snap_mute;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic signed [IN_W-1:0]   mul_a;
  logic signed [GAIN_W:0]   mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     last_ch;
  logic [OUT_W:0]           sat_l, sat_r;

  sample_strobe_sync u_sync (
    .clk32    (clk32),
    .rst      (rst),
    .async_i  (sample_clk_i),
    .strobe_o (strobe)
  );

  // Single shared multiplier; gain is zero-extended so it stays non-negative
  always_comb begin
    mul_a    = snap_data[32'(idx)*IN_W +: IN_W];
    mul_b    = {1'b0, snap_gain[32'(idx)*GAIN_W +: GAIN_W]};
    prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
    prod_ext = ACC_W'(prod);
    last_ch  = (idx == IDX_W'(NUM_CH - 1));
    sat_l    = saturate(acc_l);
    sat_r    = saturate(acc_r);
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (strobe) state_nxt = ST_MAC;
      ST_MAC:  if (last_ch) state_nxt = ST_SAT;
      ST_SAT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      snap_data <= '0;
      snap_gain <= '0;
      snap_rl   <= '0;
      snap_rr   <= '0;
      snap_mute <= 1'b0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      left_o    <= '0;
      right_o   <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      clip_l_o  <= 1'b0;
      clip_r_o  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (strobe) begin
          snap_data <= ch_data_i;
          snap_gain <= gain_i;
          snap_rl   <= route_l_i;
          snap_rr   <= route_r_i;
          snap_mute <= mute_i;
          acc_l     <= '0;
          acc_r     <= '0;
          idx       <= '0;
        end
        ST_MAC: begin
          if (snap_rl[idx]) acc_l <= acc_l + prod_ext;
          if (snap_rr[idx]) acc_r <= acc_r + prod_ext;
          idx <= idx + IDX_W'(1);
        end
        ST_SAT: begin
          left_o  <= snap_mute ? '0 : sat_l[OUT_W-1:0];
          right_o <= snap_mute ? '0 : sat_r[OUT_W-1:0];
        end
        default: ;
      endcase
      valid_o   <= (state == ST_SAT);
      busy_o    <= (state_nxt != ST_IDLE);
      // sticky flags: a set in the same cycle as a clear wins
      clip_l_o  <= (clip_l_o & ~clr_flags_i) | ((state == ST_SAT) & ~snap_mute & sat_l[OUT_W]);
      clip_r_o  <= (clip_r_o & ~clr_flags_i) | ((state == ST_SAT) & ~snap_mute & sat_r[OUT_W]);
      overrun_o <= (overrun_o & ~clr_flags_i) | (strobe & (state != ST_IDLE));
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: two instances (4x16 and 8x24) share clock,
// reset and sample clock; a reference model predicts every stereo sample.
module tb_audio_mixer;

  typedef struct {
    longint l;
    longint r;
    bit     cl;
    bit     cr;
    bit     ovr;
    longint cyc;
  } exp_t;

  logic clk32 = 1'b0;
  logic rst;
  logic sample_clk;

  logic [63:0]  ch_data_a;  logic [31:0] gain_a;
  logic [3:0]   route_l_a, route_r_a;
  logic [191:0] ch_data_b;  logic [63:0] gain_b;
  logic [7:0]   route_l_b, route_r_b;
  logic         mute_a, mute_b, clr;

  logic [15:0] left_a, right_a;
  logic [23:0] left_b, right_b;
  logic valid_a, busy_a, clip_l_a, clip_r_a, ovr_a;
  logic valid_b, busy_b, clip_l_b, clip_r_b, ovr_b;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  exp_t   q_a[$];
  exp_t   q_b[$];

  // per-instance stimulus and model state (index 0 = A, 1 = B)
  longint      d[2][16];
  longint      g[2][16];
  int unsigned rl[2], rr[2];
  bit          mu[2];
  bit          st_cl[2], st_cr[2], st_ov[2];
  int          nch[2] = '{4, 8};
  int          iw[2]  = '{16, 24};
  int          ow[2]  = '{16, 24};

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  audio_mixer dut_a (
    .clk32(clk32), .rst(rst), .sample_clk_i(sample_clk),
    .ch_data_i(ch_data_a), .gain_i(gain_a), .route_l_i(route_l_a), .route_r_i(route_r_a),
    .mute_i(mute_a), .clr_flags_i(clr),
    .left_o(left_a), .right_o(right_a), .valid_o(valid_a), .busy_o(busy_a),
    .clip_l_o(clip_l_a), .clip_r_o(clip_r_a), .overrun_o(ovr_a)
  );

  audio_mixer #(.NUM_CH(8), .IN_W(24), .GAIN_W(8), .OUT_W(24)) dut_b (
    .clk32(clk32), .rst(rst), .sample_clk_i(sample_clk),
    .ch_data_i(ch_data_b), .gain_i(gain_b), .route_l_i(route_l_b), .route_r_i(route_r_b),
    .mute_i(mute_b), .clr_flags_i(clr),
    .left_o(left_b), .right_o(right_b), .valid_o(valid_b), .busy_o(busy_b),
    .clip_l_o(clip_l_b), .clip_r_o(clip_r_b), .overrun_o(ovr_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void clamp(input longint v, input int w, output longint o, output bit c);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    c  = (v > hi) || (v < lo);
    o  = (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Mix as a sum of routed products divided by unity gain, rounded toward -inf
  function automatic void ref_mix(input longint dd[16], input longint gg[16],
                                  input int unsigned ml, input int unsigned mr, input bit mute,
                                  input int n, input int w,
                                  output longint lo, output longint ro,
                                  output bit cl, output bit cr);
    longint sl, sr;
    sl = 0;
    sr = 0;
    for (int k = 0; k < n; k++) begin
      if (ml[k]) sl += dd[k] * gg[k];
      if (mr[k]) sr += dd[k] * gg[k];
    end
    clamp(floor_div(sl, 128), w, lo, cl);
    clamp(floor_div(sr, 128), w, ro, cr);
    if (mute) begin
      lo = 0; ro = 0; cl = 0; cr = 0;
    end
  endfunction

  function automatic longint rand_signed(input int w);
    longint v;
    v = longint'($urandom) & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic randomize_dut(input int i);
    for (int k = 0; k < 16; k++) begin
      d[i][k] = rand_signed(iw[i]);
      g[i][k] = longint'($urandom_range(0, 255));
    end
    rl[i] = $urandom;
    rr[i] = $urandom;
    mu[i] = ($urandom_range(0, 7) == 0);
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      ch_data_a[k*16 +: 16] = 16'(d[0][k]);
      gain_a[k*8 +: 8]      = 8'(g[0][k]);
    end
    for (int k = 0; k < 8; k++) begin
      ch_data_b[k*24 +: 24] = 24'(d[1][k]);
      gain_b[k*8 +: 8]      = 8'(g[1][k]);
    end
    route_l_a = 4'(rl[0]); route_r_a = 4'(rr[0]); mute_a = mu[0];
    route_l_b = 8'(rl[1]); route_r_b = 8'(rr[1]); mute_b = mu[1];
  endtask

  task automatic scramble();
    ch_data_a = {$urandom, $urandom};
    gain_a    = $urandom;
    route_l_a = 4'($urandom); route_r_a = 4'($urandom); mute_a = 1'($urandom);
    for (int k = 0; k < 8; k++) ch_data_b[k*24 +: 24] = 24'($urandom);
    gain_b    = {$urandom, $urandom};
    route_l_b = 8'($urandom); route_r_b = 8'($urandom); mute_b = 1'($urandom);
  endtask

  task automatic push_expected(input longint start, input bit ovr);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      ref_mix(d[i], g[i], rl[i], rr[i], mu[i], nch[i], ow[i], e.l, e.r, e.cl, e.cr);
      st_cl[i] |= e.cl;
      st_cr[i] |= e.cr;
      st_ov[i] |= ovr;
      e.cl  = st_cl[i];
      e.cr  = st_cr[i];
      e.ovr = st_ov[i];
      e.cyc = start + nch[i] + 5;
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d,%0d pending required=0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (3) tick();
  endtask

  // One sample edge; inputs are scrambled after capture, or a second edge is
  // fired mid-mix to provoke an overrun
  task automatic run_txn(input bit ovr);
    longint start;
    drive();
    tick();
    sample_clk = 1'b1;
    start = cyc;
    push_expected(start, ovr);
    if (!ovr) begin
      repeat (4) tick();
      check("busy_a_after_capture", longint'(busy_a), 1);
      check("busy_b_after_capture", longint'(busy_b), 1);
      repeat (8) begin
        scramble();
        tick();
      end
      sample_clk = 1'b0;
    end else begin
      repeat (2) tick();
      sample_clk = 1'b0;
      repeat (2) tick();
      sample_clk = 1'b1;
      repeat (3) tick();
      sample_clk = 1'b0;
    end
    wait_drain();
  endtask

  task automatic clear_flags();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_cl[i] = 0; st_cr[i] = 0; st_ov[i] = 0;
    end
    check("clr_clip_l_a", longint'(clip_l_a), 0);
    check("clr_clip_r_a", longint'(clip_r_a), 0);
    check("clr_ovr_a", longint'(ovr_a), 0);
    check("clr_clip_l_b", longint'(clip_l_b), 0);
    check("clr_ovr_b", longint'(ovr_b), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_left_a"}, longint'(left_a), 0);
    check({tag, "_right_a"}, longint'(right_a), 0);
    check({tag, "_valid_a"}, longint'(valid_a), 0);
    check({tag, "_busy_a"}, longint'(busy_a), 0);
    check({tag, "_flags_a"}, longint'({clip_l_a, clip_r_a, ovr_a}), 0);
    check({tag, "_left_b"}, longint'(left_b), 0);
    check({tag, "_right_b"}, longint'(right_b), 0);
    check({tag, "_valid_b"}, longint'(valid_b), 0);
    check({tag, "_busy_b"}, longint'(busy_b), 0);
    check({tag, "_flags_b"}, longint'({clip_l_b, clip_r_b, ovr_b}), 0);
  endtask

  // Monitor: every valid pulse must match the oldest expected sample
  always @(negedge clk32) begin
    exp_t e;
    if (!rst && valid_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_valid actual=1 required=0 left=%0d", $signed(left_a));
      end else begin
        e = q_a.pop_front();
        check("a_left", longint'($signed(left_a)), e.l);
        check("a_right", longint'($signed(right_a)), e.r);
        check("a_clip_l", longint'(clip_l_a), longint'(e.cl));
        check("a_clip_r", longint'(clip_r_a), longint'(e.cr));
        check("a_overrun", longint'(ovr_a), longint'(e.ovr));
        check("a_latency", cyc, e.cyc);
        check("a_busy_at_valid", longint'(busy_a), 0);
      end
    end
    if (!rst && valid_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_valid actual=1 required=0 left=%0d", $signed(left_b));
      end else begin
        e = q_b.pop_front();
        check("b_left", longint'($signed(left_b)), e.l);
        check("b_right", longint'($signed(right_b)), e.r);
        check("b_clip_l", longint'(clip_l_b), longint'(e.cl));
        check("b_clip_r", longint'(clip_r_b), longint'(e.cr));
        check("b_overrun", longint'(ovr_b), longint'(e.ovr));
        check("b_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    sample_clk = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_dut(i);
      st_cl[i] = 0; st_cr[i] = 0; st_ov[i] = 0;
    end
    drive();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) tick();

    // Basic routing at unity gain
    randomize_dut(1);
    d[0][0] = 1000; d[0][1] = 2000; d[0][2] = 3000; d[0][3] = 4000;
    for (int k = 0; k < 4; k++) g[0][k] = 128;
    rl[0] = 4'b0101; rr[0] = 4'b1010; mu[0] = 0;
    run_txn(0);

    // Positive then negative saturation on the left, then clear
    randomize_dut(1);
    d[0][0] = 30000; d[0][1] = 5; d[0][2] = 30000; d[0][3] = -7;
    rl[0] = 4'b0101; rr[0] = 4'b0000;
    run_txn(0);
    d[0][0] = -30000; d[0][2] = -30000;
    run_txn(0);
    clear_flags();

    // Half gain with floor rounding on negative input
    d[0][0] = 1001; g[0][0] = 64; rl[0] = 4'b0001; rr[0] = 4'b0001;
    run_txn(0);
    d[0][0] = -1001;
    run_txn(0);

    // Second sample edge during the mix
    randomize_dut(0); randomize_dut(1);
    mu[0] = 0; mu[1] = 0;
    run_txn(1);
    clear_flags();

    // Wide instance: eight channels to both sides, then muted
    for (int k = 0; k < 8; k++) begin
      d[1][k] = 100000; g[1][k] = 128;
    end
    rl[1] = 8'hFF; rr[1] = 8'hFF; mu[1] = 0;
    run_txn(0);
    mu[1] = 1;
    run_txn(0);

    // Reset mid-mix with the sample clock held high through release
    randomize_dut(0); randomize_dut(1);
    drive();
    tick();
    sample_clk = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_all_zero("midmix_rst");
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_cl[i] = 0; st_cr[i] = 0; st_ov[i] = 0;
    end
    repeat (20) tick();
    check("rst_high_no_strobe_busy_a", longint'(busy_a), 0);
    sample_clk = 1'b0;
    repeat (5) tick();
    run_txn(0);

    // Randomised mixes
    for (int t = 0; t < 24; t++) begin
      randomize_dut(0);
      randomize_dut(1);
      run_txn(0);
      if (t % 8 == 7) clear_flags();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
